// File: rtl/switch_node.sv
// Device-side switch endpoint: TX FIFO feeding a four-phase request/ack sender and an RX receiver feeding an RX FIFO.
// Optional REQ watchdog with sticky err_o is enabled by defining SWITCH_NODE_TIMEOUT_EN.
module switch_node #(
   parameter int AW_DEV    = 2,
   parameter int DW        = 4,
   parameter int DEPTH     = 2,
   parameter int TO_CYCLES = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tx_we_i,
   input  logic [AW_DEV-1:0] tx_adr_i,
   input  logic [DW-1:0]     tx_dat_i,
   output logic              tx_full_o,
   input  logic              rx_re_i,
   output logic [DW-1:0]     rx_dat_o,
   output logic              rx_empty_o,
   output logic              validtx_o,
   output logic [AW_DEV-1:0] adr_o,
   output logic [DW-1:0]     dat_o,
   input  logic              acktx_i,
   input  logic              validrx_i,
   input  logic [DW-1:0]     dat_i,
   output logic              ackrx_o,
   output logic              err_o
);

   localparam int N  = 1 << DEPTH;
   localparam int TW = AW_DEV + DW;

   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_RELEASE} tx_state_e;
   typedef enum logic       {RX_IDLE, RX_HOLD} rx_state_e;

   tx_state_e         tx_state_q, tx_state_d;
   rx_state_e         rx_state_q, rx_state_d;
   logic [DEPTH:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [DEPTH:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [TW-1:0]     tx_mem_q [N];
   logic [DW-1:0]     rx_mem_q [N];
   logic              validtx_q, validtx_d;
   logic [AW_DEV-1:0] adr_q, adr_d;
   logic [DW-1:0]     dat_q, dat_d;
   logic              ackrx_q, ackrx_d;
   logic              tx_empty, tx_push, tx_pop;
   logic              rx_full, rx_push, rx_pop;

`ifdef SWITCH_NODE_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign tx_empty  = (tx_wptr_q == tx_rptr_q);
   assign tx_full_o = (tx_wptr_q[DEPTH] != tx_rptr_q[DEPTH]) &&
                      (tx_wptr_q[DEPTH-1:0] == tx_rptr_q[DEPTH-1:0]);
   assign rx_empty_o = (rx_wptr_q == rx_rptr_q);
   assign rx_full    = (rx_wptr_q[DEPTH] != rx_rptr_q[DEPTH]) &&
                       (rx_wptr_q[DEPTH-1:0] == rx_rptr_q[DEPTH-1:0]);

   assign tx_pop  = (tx_state_q == TX_IDLE) && !tx_empty;
   assign tx_push = tx_we_i && (!tx_full_o || tx_pop);
   assign rx_push = (rx_state_q == RX_IDLE) && validrx_i && !rx_full;
   assign rx_pop  = rx_re_i && !rx_empty_o;

   // NOTE: storage arrays have no reset; the empty flag masks stale contents on rx_dat_o.
   assign rx_dat_o = rx_empty_o ? '0 : rx_mem_q[rx_rptr_q[DEPTH-1:0]];

   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem_q[tx_wptr_q[DEPTH-1:0]] <= {tx_adr_i, tx_dat_i};
      if (rx_push) rx_mem_q[rx_wptr_q[DEPTH-1:0]] <= dat_i;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      tx_state_d = tx_state_q;
      validtx_d  = validtx_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      tx_wptr_d  = tx_wptr_q + (DEPTH+1)'(tx_push);
      tx_rptr_d  = tx_rptr_q + (DEPTH+1)'(tx_pop);
`ifdef SWITCH_NODE_TIMEOUT_EN
      cnt_d = cnt_q;
      err_d = err_q;
`endif
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               {adr_d, dat_d} = tx_mem_q[tx_rptr_q[DEPTH-1:0]];
               validtx_d      = 1'b1;
               tx_state_d     = TX_REQ;
`ifdef SWITCH_NODE_TIMEOUT_EN
               cnt_d = '0;
`endif
            end
         end
         TX_REQ: begin
            if (acktx_i) begin
               validtx_d  = 1'b0;
               tx_state_d = TX_RELEASE;
            end
`ifdef SWITCH_NODE_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               validtx_d  = 1'b0;
               err_d      = 1'b1;
               tx_state_d = TX_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         TX_RELEASE: begin
            if (!acktx_i) tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      ackrx_d    = ackrx_q;
      rx_wptr_d  = rx_wptr_q + (DEPTH+1)'(rx_push);
      rx_rptr_d  = rx_rptr_q + (DEPTH+1)'(rx_pop);
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_push) begin
               ackrx_d    = 1'b1;
               rx_state_d = RX_HOLD;
            end
         end
         RX_HOLD: begin
            if (!validrx_i) begin
               ackrx_d    = 1'b0;
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_state_q <= TX_IDLE;
         rx_state_q <= RX_IDLE;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         validtx_q  <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         ackrx_q    <= 1'b0;
`ifdef SWITCH_NODE_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         validtx_q  <= validtx_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         ackrx_q    <= ackrx_d;
`ifdef SWITCH_NODE_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign validtx_o = validtx_q;
   assign adr_o     = adr_q;
   assign dat_o     = dat_q;
   assign ackrx_o   = ackrx_q;
`ifdef SWITCH_NODE_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
